// File: rtl/ysyx_220053_mem_pkg.sv
// Shared definitions for the cache/memory refill path: FSM encoding, memory
// command codes and the default address/line widths.
package ysyx_220053_mem_pkg;

    localparam int unsigned MEM_AW = 64;
    localparam int unsigned MEM_DW = 128;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    // Request/grant vector bit positions shared by the picker and the top
    localparam int unsigned REQ_I_BIT = 0;
    localparam int unsigned REQ_D_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_e;

endpackage

// File: rtl/ysyx_220053_rr_arb2.sv
// Two-way round-robin picker: on contention the side that did not win last
// time is chosen; with no history yet, D_FIRST breaks the tie.
module ysyx_220053_rr_arb2
    import ysyx_220053_mem_pkg::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic [1:0] req,
    input  arb_side_e  last_grant,
    input  logic       has_history,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant[REQ_I_BIT] = 1'b1;
            2'b10: grant[REQ_D_BIT] = 1'b1;
            2'b11: begin
                if (!has_history) begin
                    if (D_FIRST) grant[REQ_D_BIT] = 1'b1;
                    else         grant[REQ_I_BIT] = 1'b1;
                end else if (last_grant == SIDE_D) begin
                    grant[REQ_I_BIT] = 1'b1;
                end else begin
                    grant[REQ_D_BIT] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_220053_mem_arbiter.sv
// Shares the single refill/writeback memory port between the I-cache and the
// D-cache, one transaction at a time, round-robin on contention.
module ysyx_220053_mem_arbiter
    import ysyx_220053_mem_pkg::*;
#(
    parameter int unsigned AW      = MEM_AW,
    parameter int unsigned DW      = MEM_DW,
    parameter bit          D_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] i_rw_addr_i,
    input  logic          i_rw_req_i,
    input  logic          i_rw_valid_i,
    output logic [DW-1:0] i_data_read_o,
    output logic          i_rw_ready_o,

    input  logic [AW-1:0] d_rw_addr_i,
    input  logic          d_rw_req_i,
    input  logic          d_rw_valid_i,
    input  logic [DW-1:0] d_data_write_i,
    output logic [DW-1:0] d_data_read_o,
    output logic          d_rw_ready_o,

    output logic [AW-1:0] m_rw_addr_o,
    output logic          m_rw_req_o,
    output logic          m_rw_valid_o,
    output logic [DW-1:0] m_data_write_o,
    input  logic [DW-1:0] m_data_read_i,
    input  logic          m_rw_ready_i
);

    arb_state_e state;
    arb_side_e  last_grant;
    logic       has_history;
    logic [1:0] grant;

    ysyx_220053_rr_arb2 #(
        .D_FIRST (D_FIRST)
    ) u_rr_arb2 (
        .req         ({d_rw_valid_i, i_rw_valid_i}),
        .last_grant  (last_grant),
        .has_history (has_history),
        .grant       (grant)
    );

    // Grant FSM; a dropped valid abandons the grant without a ready pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= SIDE_I;
            has_history <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant[REQ_D_BIT]) begin
                        state       <= ST_GNT_D;
                        last_grant  <= SIDE_D;
                        has_history <= 1'b1;
                    end else if (grant[REQ_I_BIT]) begin
                        state       <= ST_GNT_I;
                        last_grant  <= SIDE_I;
                        has_history <= 1'b1;
                    end
                end
                ST_GNT_I: begin
                    if (!i_rw_valid_i)     state <= ST_IDLE;
                    else if (m_rw_ready_i) state <= ST_DONE;
                end
                ST_GNT_D: begin
                    if (!d_rw_valid_i)     state <= ST_IDLE;
                    else if (m_rw_ready_i) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request passthrough and response routing; the idle side always sees zeros
    always_comb begin
        m_rw_addr_o    = '0;
        m_rw_req_o     = MEM_CMD_READ;
        m_rw_valid_o   = 1'b0;
        m_data_write_o = '0;
        i_rw_ready_o   = 1'b0;
        i_data_read_o  = '0;
        d_rw_ready_o   = 1'b0;
        d_data_read_o  = '0;
        case (state)
            ST_GNT_I: begin
                m_rw_addr_o  = i_rw_addr_i;
                m_rw_valid_o = i_rw_valid_i;
                if (i_rw_valid_i && m_rw_ready_i) begin
                    i_rw_ready_o  = 1'b1;
                    i_data_read_o = m_data_read_i;
                end
            end
            ST_GNT_D: begin
                m_rw_addr_o    = d_rw_addr_i;
                m_rw_req_o     = d_rw_req_i;
                m_rw_valid_o   = d_rw_valid_i;
                m_data_write_o = d_data_write_i;
                if (d_rw_valid_i && m_rw_ready_i) begin
                    d_rw_ready_o  = 1'b1;
                    d_data_read_o = m_data_read_i;
                end
            end
            default: ;
        endcase
    end

    // Requesters must hold valid until ready; the I-side never writes
    a_i_hold: assert property (@(posedge clk) disable iff (rst)
        (state == ST_GNT_I) |-> i_rw_valid_i);
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (state == ST_GNT_D) |-> d_rw_valid_i);
    a_i_read: assert property (@(posedge clk) disable iff (rst)
        (state == ST_GNT_I) |-> (i_rw_req_i == MEM_CMD_READ));

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Scoreboard bench for the I/D memory arbiter: directed requesters, a
// latency-programmable memory responder and a ready-pulse monitor.
module tb_ysyx_220053_mem_arbiter;
    import ysyx_220053_mem_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_rw_addr_i = '0;
    logic          i_rw_req_i = 1'b0;
    logic          i_rw_valid_i = 1'b0;
    logic [DW-1:0] i_data_read_o;
    logic          i_rw_ready_o;
    logic [AW-1:0] d_rw_addr_i = '0;
    logic          d_rw_req_i = 1'b0;
    logic          d_rw_valid_i = 1'b0;
    logic [DW-1:0] d_data_write_i = '0;
    logic [DW-1:0] d_data_read_o;
    logic          d_rw_ready_o;
    logic [AW-1:0] m_rw_addr_o;
    logic          m_rw_req_o;
    logic          m_rw_valid_o;
    logic [DW-1:0] m_data_write_o;
    logic [DW-1:0] m_data_read_i = '0;
    logic          m_rw_ready_i = 1'b0;

    ysyx_220053_mem_arbiter #(.AW(AW), .DW(DW), .D_FIRST(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rw_addr_i    (i_rw_addr_i),
        .i_rw_req_i     (i_rw_req_i),
        .i_rw_valid_i   (i_rw_valid_i),
        .i_data_read_o  (i_data_read_o),
        .i_rw_ready_o   (i_rw_ready_o),
        .d_rw_addr_i    (d_rw_addr_i),
        .d_rw_req_i     (d_rw_req_i),
        .d_rw_valid_i   (d_rw_valid_i),
        .d_data_write_i (d_data_write_i),
        .d_data_read_o  (d_data_read_o),
        .d_rw_ready_o   (d_rw_ready_o),
        .m_rw_addr_o    (m_rw_addr_o),
        .m_rw_req_o     (m_rw_req_o),
        .m_rw_valid_o   (m_rw_valid_o),
        .m_data_write_o (m_data_write_o),
        .m_data_read_i  (m_data_read_i),
        .m_rw_ready_i   (m_rw_ready_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    int   checks = 0;
    int   errors = 0;
    int   lat_r = 2;
    int   lat_w = 2;
    int   spur_cnt = 0;
    int   spur_done = 0;

    // Memory contents seen by the responder, by line address
    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        if (a == 64'h8000_0000) return {32{4'h1}};
        return {a, ~a};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        check(name, DW'(act), DW'(req));
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_rw_valid_i = 1'b0;
        d_rw_valid_i = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input bit is_d);
        bit got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            got = is_d ? d_rw_ready_o : i_rw_ready_o;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout actual=no_pulse required=pulse", is_d ? "d" : "i");
        end
    endtask

    // Issue n back-to-back requests, holding valid across transactions
    task automatic side_run(input bit is_d, input logic [AW-1:0] a0, input int n,
                            input logic wr, input logic [DW-1:0] wd);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] a;
            a = a0 + AW'(k * 16);
            if (is_d) begin
                d_rw_addr_i = a;
                d_rw_req_i = wr;
                d_data_write_i = wd;
                d_rw_valid_i = 1'b1;
            end else begin
                i_rw_addr_i = a;
                i_rw_req_i = 1'b0;
                i_rw_valid_i = 1'b1;
            end
            wait_ready(is_d);
            @(posedge clk);
            #1;
        end
        if (is_d) d_rw_valid_i = 1'b0;
        else      i_rw_valid_i = 1'b0;
    endtask

    // Memory responder: ready after lat_r/lat_w cycles of valid, one-cycle pulse
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            m_rw_ready_i = 1'b0;
            m_data_read_i = '0;
            if (rst || !m_rw_valid_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= (m_rw_req_o ? lat_w : lat_r)) begin
                    m_rw_ready_i = 1'b1;
                    m_data_read_i = line_of(m_rw_addr_o);
                    cnt = 0;
                end
            end
            if (spur_cnt != spur_done) begin
                m_rw_ready_i = 1'b1;
                m_data_read_i = '1;
                spur_done = spur_cnt;
            end
        end
    end

    // Monitor: every ready pulse must match the head of that side's queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!i_rw_ready_o) check("i_data_quiet", i_data_read_o, '0);
            if (!d_rw_ready_o) check("d_data_quiet", d_data_read_o, '0);
            if (i_rw_ready_o) begin
                if (exp_i.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL i_ready_unexpected cyc=%0d actual=1 required=0", cyc);
                end else begin
                    e = exp_i.pop_front();
                    check("i_data", i_data_read_o, e.data);
                    check_int("i_ready_cycle", cyc, e.cyc);
                end
            end
            if (d_rw_ready_o) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d_ready_unexpected cyc=%0d actual=1 required=0", cyc);
                end else begin
                    e = exp_d.pop_front();
                    check("d_data", d_data_read_o, e.data);
                    check_int("d_ready_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        logic [DW-1:0] wd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_m_valid", m_rw_valid_o, 1'b0);
        check1("rst_m_req", m_rw_req_o, 1'b0);
        check("rst_m_addr", DW'(m_rw_addr_o), '0);
        check("rst_m_wdata", m_data_write_o, '0);
        check1("rst_i_ready", i_rw_ready_o, 1'b0);
        check1("rst_d_ready", d_rw_ready_o, 1'b0);
        check("rst_i_data", i_data_read_o, '0);
        check("rst_d_data", d_data_read_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // I read only, latency 3
        step(1);
        lat_r = 3;
        c0 = cyc;
        exp_i.push_back('{data: {32{4'h1}}, cyc: c0 + 3});
        fork
            side_run(1'b0, 64'h8000_0000, 1, 1'b0, '0);
            begin
                @(negedge clk);
                check1("t1_idle_valid", m_rw_valid_o, 1'b0);
                @(negedge clk);
                check1("t1_gnt_valid", m_rw_valid_o, 1'b1);
                check("t1_gnt_addr", DW'(m_rw_addr_o), DW'(64'h8000_0000));
                check1("t1_gnt_req", m_rw_req_o, 1'b0);
                check("t1_gnt_wdata", m_data_write_o, '0);
                repeat (3) @(negedge clk);
                check1("t1_done_valid", m_rw_valid_o, 1'b0);
            end
        join

        // D write only, latency 2
        step(2);
        lat_w = 2;
        c0 = cyc;
        wd = {4{32'hDEAD_BEEF}};
        exp_d.push_back('{data: line_of(64'h8000_1000), cyc: c0 + 2});
        fork
            side_run(1'b1, 64'h8000_1000, 1, 1'b1, wd);
            begin
                repeat (2) @(negedge clk);
                check1("t2_gnt_valid", m_rw_valid_o, 1'b1);
                check1("t2_gnt_req", m_rw_req_o, 1'b1);
                check("t2_gnt_addr", DW'(m_rw_addr_o), DW'(64'h8000_1000));
                check("t2_gnt_wdata", m_data_write_o, wd);
            end
        join

        // Simultaneous after reset: D first, then I right after DONE
        step(2);
        do_reset();
        step(1);
        lat_w = 4;
        lat_r = 2;
        c0 = cyc;
        exp_d.push_back('{data: line_of(64'h8000_2000), cyc: c0 + 4});
        exp_i.push_back('{data: line_of(64'h8000_3000), cyc: c0 + 8});
        fork
            side_run(1'b1, 64'h8000_2000, 1, 1'b1, {2{64'h0123_4567_89AB_CDEF}});
            side_run(1'b0, 64'h8000_3000, 1, 1'b0, '0);
            begin
                repeat (2) @(negedge clk);
                check1("t3_first_req", m_rw_req_o, 1'b1);
                check("t3_first_addr", DW'(m_rw_addr_o), DW'(64'h8000_2000));
                repeat (6) @(negedge clk);
                check1("t3_second_valid", m_rw_valid_o, 1'b1);
                check("t3_second_addr", DW'(m_rw_addr_o), DW'(64'h8000_3000));
                check1("t3_second_req", m_rw_req_o, 1'b0);
            end
        join

        // Both held for 6 transactions: D, I, D, I, D, I
        step(2);
        do_reset();
        step(1);
        lat_r = 2;
        lat_w = 2;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_d.push_back('{data: line_of(64'h8000_4000 + 64'(16 * k)), cyc: c0 + 2 + 8 * k});
            exp_i.push_back('{data: line_of(64'h8000_5000 + 64'(16 * k)), cyc: c0 + 6 + 8 * k});
        end
        fork
            side_run(1'b1, 64'h8000_4000, 3, 1'b0, '0);
            side_run(1'b0, 64'h8000_5000, 3, 1'b0, '0);
        join

        // Reset one cycle before the memory would answer a D write
        step(2);
        lat_w = 3;
        d_rw_addr_i = 64'h8000_6000;
        d_rw_req_i = 1'b1;
        d_data_write_i = {8{16'hA5A5}};
        d_rw_valid_i = 1'b1;
        step(2);
        check1("t5_pre_rst_valid", m_rw_valid_o, 1'b1);
        rst = 1'b1;
        d_rw_valid_i = 1'b0;
        #1;
        check1("t5_rst_valid", m_rw_valid_o, 1'b0);
        check1("t5_rst_d_ready", d_rw_ready_o, 1'b0);
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check1("t5_post_valid", m_rw_valid_o, 1'b0);
        @(posedge clk);
        #1;
        lat_r = 1;
        c0 = cyc;
        exp_d.push_back('{data: line_of(64'h8000_7000), cyc: c0 + 1});
        side_run(1'b1, 64'h8000_7000, 1, 1'b0, '0);

        // Spurious memory ready while idle is ignored
        step(2);
        spur_cnt++;
        @(negedge clk);
        check1("t6_spur_i_ready", i_rw_ready_o, 1'b0);
        check1("t6_spur_d_ready", d_rw_ready_o, 1'b0);
        check1("t6_spur_valid", m_rw_valid_o, 1'b0);
        @(posedge clk);
        #1;
        lat_r = 1;
        c0 = cyc;
        exp_i.push_back('{data: line_of(64'h8000_8000), cyc: c0 + 1});
        side_run(1'b0, 64'h8000_8000, 1, 1'b0, '0);

        step(3);
        check_int("exp_i_drained", exp_i.size(), 0);
        check_int("exp_d_drained", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
